hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Pipeline control unit for the fetch/decode and decode/execute pipeline registers.
- Generates the PC enable, F/D enable and kill, and D/X enable and bubble signals.
- Handles load-use hazards, taken-branch flushes, memory-wait freezes, and multi-cycle multiply/divide (MDU) occupancy.
- Sits beside the F/D register; `fd_kill` drives that register's decode-enable input low so that a NOP enters decode.

Parameters:
- MDU_LATENCY, 32, number of cycles the MDU stays busy after a start is accepted (legal values ≥1).
- STALL_CNT_W, 32, width of the stall performance counter.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- d_valid  in  1  decode stage holds a real instruction (F/D decode-enable output).
- d_rs  in  5  decode source register rs.
- d_rt  in  5  decode source register rt.
- d_uses_rt  in  1  decode instruction reads rt.
- d_is_mdu  in  1  decode instruction is mult/div/mfhi/mflo/mthi/mtlo.
- x_valid  in  1  execute stage holds a real instruction.
- x_rd  in  5  execute-stage destination register.
- x_mem_read  in  1  execute instruction is a load.
- x_mdu_start  in  1  execute instruction launches a mult/div.
- x_branch_taken  in  1  branch/jump resolved taken in execute.
- mem_req  in  1  memory stage has an access outstanding.
- mem_ack  in  1  memory completes the access this cycle.
- pc_enable  out  1  PC register load enable.
- fd_enable  out  1  F/D register load enable.
- fd_kill  out  1  force F/D decode-enable to 0 on load.
- dx_enable  out  1  D/X register load enable.
- dx_bubble  out  1  load NOP into D/X.
- mdu_busy  out  1  MDU occupied.
- stall_cycles  out  STALL_CNT_W  count of cycles with pc_enable=0.

Behaviour:
- **States:** RUN and MDU_WAIT. There is a down-counter `mdu_cnt` of width clog2(MDU_LATENCY+1).
- **Outputs:** all outputs are combinational from the state and current inputs, except `stall_cycles`, which is registered.
- **Reset:**
  - state=RUN, mdu_cnt=0, stall_cycles=0.
  - While reset=1: pc_enable=0, fd_enable=1, fd_kill=1, dx_enable=1, dx_bubble=1, mdu_busy=0. This loads NOPs into both registers.
  - Reset mid-MDU abandons the operation immediately.
- **Freeze** (mem_req & !mem_ack), any state: all four of pc_enable, fd_enable, dx_enable, fd_kill are 0; dx_bubble=0. Freeze has highest priority. It does not stop mdu_cnt. x_mdu_start is ignored during freeze.
- **Flush** (x_branch_taken, no freeze):
  - pc_enable=1, fd_enable=1, fd_kill=1, dx_enable=1, dx_bubble=1.
  - Overrides any load-use or MDU stall on the same cycle.
- **Load-use hazard**, no freeze and no flush. Condition: x_valid & x_mem_read & x_rd≠0 & d_valid & (x_rd==d_rs | (d_uses_rt & x_rd==d_rt)).
  - Outputs: pc_enable=0, fd_enable=0, dx_enable=1, dx_bubble=1.
  - Lasts exactly one cycle; the bubble in execute clears the condition.
- **MDU hazard** (state MDU_WAIT & d_valid & d_is_mdu, no freeze/flush): same outputs as load-use; repeats until MDU_WAIT is left.
- **Default:** pc_enable=fd_enable=dx_enable=1; fd_kill=dx_bubble=0.
- **RUN → MDU_WAIT:** when x_mdu_start & x_valid & no freeze. Load mdu_cnt=MDU_LATENCY.
- **MDU_WAIT:**
  - mdu_cnt decrements every cycle, including during freeze.
  - When mdu_cnt==1, the next state is RUN and mdu_cnt becomes 0.
  - mdu_busy=1 for exactly MDU_LATENCY cycles following the start cycle.
  - A new x_mdu_start in MDU_WAIT cannot legally occur (decode is stalled) and is ignored.
- **stall_cycles:** +1 on every non-reset cycle with pc_enable=0; saturates at all-ones and does not wrap.
- **Register 0:** hazards never trigger on register 0.

Test Plan:
- Reset held 3 cycles, then released -> while reset=1: pc_enable=0, fd_kill=1, dx_bubble=1. After release: pc_enable=fd_enable=dx_enable=1, stall_cycles=0, mdu_busy=0.
- x: load to r5; d: rs=5, d_valid=1 -> 1 cycle of pc_enable=0, fd_enable=0, dx_bubble=1; next cycle (x_valid=0) all enables 1; stall_cycles=1. Repeat with x_rd=0 -> no stall.
- MDU_LATENCY=4, x_mdu_start pulse, then d_is_mdu=1 held -> mdu_busy high 4 cycles; pc_enable=0 for those 4 cycles; state RUN and pc_enable=1 on cycle 5.
- x_branch_taken=1 coincident with a load-use hazard -> fd_kill=1, dx_bubble=1, pc_enable=1 (flush wins); stall_cycles unchanged.
- mem_req=1, mem_ack=0 for 3 cycles during MDU_WAIT (MDU_LATENCY=4) -> all enables 0 for 3 cycles; mdu_busy still drops after 4 cycles; stall_cycles +3 minimum.
- Force stall_cycles to all-ones via STALL_CNT_W=4 and 20 stall cycles -> counter holds 15, no wrap; reset mid-MDU_WAIT -> mdu_busy=0 on the next cycle.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller for the F/D and D/X registers.
// Latency: enables/kill/bubble are combinational from state and inputs; stall_cycles is registered.
// Backpressure: memory freeze beats branch flush, which beats load-use and MDU stalls.
module hazard_stall_ctrl #(
    parameter int MDU_LATENCY = 32,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   d_valid,
    input  logic [4:0]             d_rs,
    input  logic [4:0]             d_rt,
    input  logic                   d_uses_rt,
    input  logic                   d_is_mdu,
    input  logic                   x_valid,
    input  logic [4:0]             x_rd,
    input  logic                   x_mem_read,
    input  logic                   x_mdu_start,
    input  logic                   x_branch_taken,
    input  logic                   mem_req,
    input  logic                   mem_ack,
    output logic                   pc_enable,
    output logic                   fd_enable,
    output logic                   fd_kill,
    output logic                   dx_enable,
    output logic                   dx_bubble,
    output logic                   mdu_busy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int CNT_W = $clog2(MDU_LATENCY + 1);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   mdu_cnt;

    logic freeze;
    logic load_use;
    logic mdu_hazard;

    // Memory wait freezes everything; register 0 never creates a dependency.
    assign freeze     = mem_req & ~mem_ack;
    assign load_use   = x_valid & x_mem_read & (x_rd != 5'd0) & d_valid &
                        ((x_rd == d_rs) | (d_uses_rt & (x_rd == d_rt)));
    assign mdu_hazard = (state == MDU_WAIT) & d_valid & d_is_mdu;

    // Pipeline register controls, in priority order: reset, freeze, flush, stall, run.
    always_comb begin
        pc_enable = 1'b1;
        fd_enable = 1'b1;
        fd_kill   = 1'b0;
        dx_enable = 1'b1;
        dx_bubble = 1'b0;
        mdu_busy  = ~reset & (state == MDU_WAIT);
        if (reset) begin
            pc_enable = 1'b0;
            fd_kill   = 1'b1;
            dx_bubble = 1'b1;
        end else if (freeze) begin
            pc_enable = 1'b0;
            fd_enable = 1'b0;
            dx_enable = 1'b0;
        end else if (x_branch_taken) begin
            fd_kill   = 1'b1;
            dx_bubble = 1'b1;
        end else if (load_use | mdu_hazard) begin
            pc_enable = 1'b0;
            fd_enable = 1'b0;
            dx_bubble = 1'b1;
        end
    end

    // MDU occupancy: the down-counter keeps running through freezes so busy lasts exactly MDU_LATENCY cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= RUN;
            mdu_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (x_mdu_start & x_valid & ~freeze) begin
                        state   <= MDU_WAIT;
                        mdu_cnt <= CNT_W'(MDU_LATENCY);
                    end
                end
                MDU_WAIT: begin
                    if (mdu_cnt == CNT_W'(1)) begin
                        state   <= RUN;
                        mdu_cnt <= '0;
                    end else begin
                        mdu_cnt <= mdu_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state   <= RUN;
                    mdu_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (~pc_enable && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);
        end
    end

endmodule
